// File: rtl/share_collector_pkg.sv
// ============================================================================
//  Module      : share_collector_pkg
//  Description : Shared types, defaults and helpers for the share collector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package share_collector_pkg;

    localparam int DEFAULT_NUM_SHARES    = 5;
    localparam int DEFAULT_ELEMENT_WIDTH = 4;

    typedef logic [DEFAULT_ELEMENT_WIDTH-1:0] share_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    // Index counter width; a single-share build still needs one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reduce_xor.sv
// ============================================================================
//  Module      : reduce_xor
//  Description : Combinational XOR of NUM_ELEMENTS words of ELEMENT_WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_xor #(
    parameter int NUM_ELEMENTS  = 5,
    parameter int ELEMENT_WIDTH = 4
) (
    input  logic [NUM_ELEMENTS-1:0][ELEMENT_WIDTH-1:0] in_elements,
    output logic [ELEMENT_WIDTH-1:0]                   out_xor
);

    logic [NUM_ELEMENTS-1:0][ELEMENT_WIDTH-1:0] partial;

    assign partial[0] = in_elements[0];

    generate
        for (genvar i = 1; i < NUM_ELEMENTS; i++) begin : g_chain
            assign partial[i] = partial[i-1] ^ in_elements[i];
        end
    endgenerate

    assign out_xor = partial[NUM_ELEMENTS-1];

endmodule

`default_nettype wire

// File: rtl/share_collector.sv
// ============================================================================
//  Module      : share_collector
//  Description : Collects NUM_SHARES serial share words and presents them in
//                parallel with their XOR recombination.
//                Optional: SHARE_COLLECTOR_CLEAR_EN zeroes the buffer on handoff.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module share_collector
    import share_collector_pkg::*;
#(
    parameter int NUM_SHARES    = DEFAULT_NUM_SHARES,
    parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH
) (
    input  logic                                     in_clock,
    input  logic                                     in_reset,
    input  logic                                     in_valid,
    output logic                                     out_ready,
    input  logic [ELEMENT_WIDTH-1:0]                 in_share,
    output logic                                     out_valid,
    input  logic                                     in_ready,
    output logic [NUM_SHARES-1:0][ELEMENT_WIDTH-1:0] out_shares,
    output logic [ELEMENT_WIDTH-1:0]                 out_xor
);

    localparam int               CNT_W    = cnt_width(NUM_SHARES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SHARES - 1);

    state_e                                  state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [NUM_SHARES-1:0][ELEMENT_WIDTH-1:0] buf_q, buf_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        out_valid = 1'b0;
        out_ready = 1'b0;
        case (state_q)
            COLLECT: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    for (int k = 0; k < NUM_SHARES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buf_d[k] = in_share;
                        end
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                // No same-cycle acceptance: the next set starts one edge later.
                if (in_ready) begin
                    state_d = COLLECT;
`ifdef SHARE_COLLECTOR_CLEAR_EN
                    buf_d   = '0;
`endif
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign out_shares = buf_q;

    reduce_xor #(
        .NUM_ELEMENTS  (NUM_SHARES),
        .ELEMENT_WIDTH (ELEMENT_WIDTH)
    ) u_reduce_xor (
        .in_elements (buf_q),
        .out_xor     (out_xor)
    );

endmodule

`default_nettype wire

// File: tb/tb_share_collector.sv
// ============================================================================
//  Module      : tb_share_collector
//  Description : Self-checking bench for share_collector against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_share_collector;

    localparam int NS = 5;
    localparam int EW = 4;

    logic                      clk = 1'b0;
    logic                      in_reset;
    logic                      in_valid;
    logic                      out_ready;
    logic [EW-1:0]             in_share;
    logic                      out_valid;
    logic                      in_ready;
    logic [NS-1:0][EW-1:0]     out_shares;
    logic [EW-1:0]             out_xor;

    int checks   = 0;
    int failures = 0;

    // Reference model: a set either being gathered or waiting to be taken.
    bit            m_full;
    int            m_taken;
    logic [EW-1:0] m_slot [NS];

    always #5 clk = ~clk;

    share_collector #(
        .NUM_SHARES    (NS),
        .ELEMENT_WIDTH (EW)
    ) dut (
        .in_clock   (clk),
        .in_reset   (in_reset),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_share   (in_share),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_shares (out_shares),
        .out_xor    (out_xor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] model_xor();
        logic [EW-1:0] x = '0;
        foreach (m_slot[k]) x ^= m_slot[k];
        return x;
    endfunction

    function automatic logic [31:0] model_shares();
        logic [31:0] v = '0;
        foreach (m_slot[k]) v |= 32'(m_slot[k]) << (k * EW);
        return v;
    endfunction

    task automatic check_all();
        check("out_valid",  32'(out_valid),  32'(m_full));
        check("out_ready",  32'(out_ready),  32'(!m_full));
        check("out_xor",    32'(out_xor),    32'(model_xor()));
        check("out_shares", 32'(out_shares), model_shares());
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input bit rst, input bit v, input bit r, input logic [EW-1:0] sh);
        in_reset = rst;
        in_valid = v;
        in_ready = r;
        in_share = sh;
        @(posedge clk);
        if (rst) begin
            m_full  = 1'b0;
            m_taken = 0;
            foreach (m_slot[k]) m_slot[k] = '0;
        end else if (!m_full) begin
            if (v) begin
                m_slot[m_taken] = sh;
                m_taken++;
                if (m_taken == NS) begin
                    m_full  = 1'b1;
                    m_taken = 0;
                end
            end
        end else if (r) begin
            m_full = 1'b0;
`ifdef SHARE_COLLECTOR_CLEAR_EN
            foreach (m_slot[k]) m_slot[k] = '0;
`endif
        end
        @(negedge clk);
        check_all();
    endtask

    logic [EW-1:0] set_a [NS];
    logic [EW-1:0] set_b [NS];

    initial begin
        set_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
        set_b = '{4'hA, 4'h5, 4'h0, 4'h0, 4'h1};

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check("reset_xor", 32'(out_xor), 32'h0);

        // Back-to-back set with downstream always ready.
        foreach (set_a[i]) cycle(0, 1, 1, set_a[i]);
        check("set_a_valid",  32'(out_valid),     32'h1);
        check("set_a_xor",    32'(out_xor),       32'hC);
        check("set_a_first",  32'(out_shares[0]), 32'h1);
        check("set_a_last",   32'(out_shares[4]), 32'h3);
        cycle(0, 0, 1, 0);
        check("set_a_handoff", 32'(out_valid), 32'h0);

        // Gapped valid: idle cycles must not advance the index.
        foreach (set_a[i]) begin
            cycle(0, 1, 0, set_a[i]);
            if (i < NS - 1) cycle(0, 0, 0, 4'hF);
        end
        check("gapped_xor", 32'(out_xor), 32'hC);

        // Back-pressure: new shares offered while full are ignored.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'hF);
        check("hold_xor",   32'(out_xor),   32'hC);
        check("hold_ready", 32'(out_ready), 32'h0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("single_handoff", 32'(out_valid), 32'h0);

        // Reset mid-collection discards the partial set.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, set_a[i]);
        cycle(1, 1, 1, 4'h7);
        foreach (set_b[i]) cycle(0, 1, 0, set_b[i]);
        check("post_reset_xor", 32'(out_xor), 32'hE);
        cycle(0, 0, 1, 0);
`ifdef SHARE_COLLECTOR_CLEAR_EN
        check("cleared_after_handoff", 32'(out_shares), 32'h0);
`else
        check("retained_after_handoff", 32'(out_xor), 32'hE);
`endif

        // Randomised traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 1) == 1),
                  EW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
